debug_scan_bridge: RTL and testbench

Parametrised serial debug scan bridge between a virtual-JTAG style scan port and the CPU debug logic. All JTAG-side signals (tck, tdi, state strobes, ir_in) are oversampled in the single system clock domain. The bridge shifts a DR_W-bit scan register, captures one of NUM_CH status words, and hands each completed update to the debug core through a valid/ready handshake. It replaces the fixed 38-bit, two-domain debug slave pair, adding configurable width, channel count and handshake backpressure with overrun detection.

---
 rtl/debug_scan_pkg.sv | 22 ++
 rtl/debug_scan_sync.sv | 35 +++
 rtl/debug_scan_bridge.sv | 201 ++++++++++++++++++++
 tb/tb_debug_scan_bridge.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/debug_scan_pkg.sv
// Shared types and helpers for the debug scan bridge: FSM states, ir_out
// status bit positions and the odd-parity generator used by the parity build.
package debug_scan_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } scan_state_e;

    localparam int unsigned IR_OUT_PEND = 0;
    localparam int unsigned IR_OUT_OVR  = 1;
    localparam int unsigned STATUS_W    = 2;

    // Widest word the parity helper accepts; callers zero-extend into it.
    localparam int unsigned PAR_MAX_W = 256;

    // Bit that makes the total count of ones (data plus this bit) odd.
    function automatic logic odd_parity(input logic [PAR_MAX_W-1:0] data);
        return ~(^data);
    endfunction

endpackage

// File: rtl/debug_scan_sync.sv
// Vector synchronizer, STAGES flops deep, with a rise strobe per bit taken
// from the last synchronized sample and its one-cycle-delayed copy.
module debug_scan_sync #(
    parameter int unsigned W      = 1,
    parameter int unsigned STAGES = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] d,
    output logic [W-1:0] q,
    output logic [W-1:0] rise_c
);

    logic [W-1:0] chain [STAGES];
    logic [W-1:0] prev;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(STAGES); i++) begin
                chain[i] <= '0;
            end
            prev <= '0;
        end else begin
            chain[0] <= d;
            for (int i = 1; i < int'(STAGES); i++) begin
                chain[i] <= chain[i-1];
            end
            prev <= chain[STAGES-1];
        end
    end

    assign q      = chain[STAGES-1];
    assign rise_c = q & ~prev;

endmodule

// File: rtl/debug_scan_bridge.sv
// Oversampled virtual-JTAG scan bridge: capture/shift register, update
// handoff over valid/ready with overrun flag. Optional DBG_SCAN_PARITY_EN
// adds an odd-parity bit to the scan register and checks it on update.
module debug_scan_bridge
    import debug_scan_pkg::*;
#(
    parameter int unsigned IR_W        = 2,
    parameter int unsigned DR_W        = 38,
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   tck,
    input  logic                   tdi,
    input  logic                   vs_cdr,
    input  logic                   vs_sdr,
    input  logic                   vs_udr,
    input  logic                   vs_uir,
    input  logic [IR_W-1:0]        ir_in,
    input  logic [NUM_CH*DR_W-1:0] cap_data,
    input  logic                   act_ready,
    input  logic                   clr_ovr,
    output logic                   tdo,
    output logic [IR_W-1:0]        ir_out,
    output logic [DR_W-1:0]        jdo,
    output logic [NUM_CH-1:0]      act_valid,
    output logic                   ovr,
    output logic                   par_err
);

`ifdef DBG_SCAN_PARITY_EN
    localparam int unsigned SR_W = DR_W + 1;
`else
    localparam int unsigned SR_W = DR_W;
`endif

    localparam int unsigned CTL_W   = 5;
    localparam int unsigned CTL_TCK = 0;
    localparam int unsigned CTL_CDR = 1;
    localparam int unsigned CTL_SDR = 2;
    localparam int unsigned CTL_UDR = 3;
    localparam int unsigned DAT_W   = IR_W + 1;

    logic [CTL_W-1:0] ctl_q;
    logic [CTL_W-1:0] ctl_rise_c;
    logic [DAT_W-1:0] dat_q;
    logic [DAT_W-1:0] dat_rise_unused;
    logic [5:0]       ctl_unused;

    debug_scan_sync #(.W(CTL_W), .STAGES(SYNC_STAGES)) u_ctl_sync (
        .clk    (clk),
        .reset  (reset),
        .d      ({vs_uir, vs_udr, vs_sdr, vs_cdr, tck}),
        .q      (ctl_q),
        .rise_c (ctl_rise_c)
    );

    debug_scan_sync #(.W(DAT_W), .STAGES(SYNC_STAGES)) u_dat_sync (
        .clk    (clk),
        .reset  (reset),
        .d      ({ir_in, tdi}),
        .q      (dat_q),
        .rise_c (dat_rise_unused)
    );

    // vs_uir only participates in synchronization; status is reported continuously.
    assign ctl_unused = {ctl_q[4:3], ctl_q[0], ctl_rise_c[4], ctl_rise_c[2:1]};

    logic            tck_rise_c;
    logic            cdr_sync;
    logic            sdr_sync;
    logic            tdi_sync;
    logic [IR_W-1:0] ir_sync;
    logic            udr_rise_q;

    assign tck_rise_c = ctl_rise_c[CTL_TCK];
    assign cdr_sync   = ctl_q[CTL_CDR];
    assign sdr_sync   = ctl_q[CTL_SDR];
    assign tdi_sync   = dat_q[0];
    assign ir_sync    = dat_q[DAT_W-1:1];

    // Capture word for the current instruction; unmapped channels read zero.
    logic [DR_W-1:0] cap_word;
    logic [SR_W-1:0] cap_sr;
    logic [SR_W-1:0] sr;
    logic            par_ok;

    always_comb begin
        cap_word = '0;
        for (int k = 0; k < int'(NUM_CH); k++) begin
            if (ir_sync == IR_W'(k)) begin
                cap_word = cap_data[k*DR_W +: DR_W];
            end
        end
`ifdef DBG_SCAN_PARITY_EN
        cap_sr = {odd_parity(PAR_MAX_W'(cap_word)), cap_word};
        par_ok = (sr[DR_W] == odd_parity(PAR_MAX_W'(sr[DR_W-1:0])));
`else
        cap_sr = cap_word;
        par_ok = 1'b1;
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr         <= '0;
            tdo        <= 1'b0;
            udr_rise_q <= 1'b0;
        end else begin
            if (tck_rise_c) begin
                if (cdr_sync) begin
                    sr <= cap_sr;
                end else if (sdr_sync) begin
                    sr <= {tdi_sync, sr[SR_W-1:1]};
                end
            end
            tdo        <= sr[0];
            udr_rise_q <= ctl_rise_c[CTL_UDR];
        end
    end

    scan_state_e          state_q;
    scan_state_e          state_d;
    logic [IR_W-1:0]      ch_q;
    logic [IR_W-1:0]      ch_d;
    logic [DR_W-1:0]      jdo_d;
    logic                 ovr_d;
    logic                 ovr_set;
    logic [NUM_CH-1:0]    act_valid_d;
    logic [STATUS_W-1:0]  status_d;
    logic [IR_W-1:0]      ir_out_d;
    logic                 ch_in_range;

    assign ch_in_range = ({1'b0, ir_sync} < (IR_W+1)'(NUM_CH));

    always_comb begin
        state_d  = state_q;
        ch_d     = ch_q;
        jdo_d    = jdo;
        ovr_set  = 1'b0;
        status_d = '0;
        case (state_q)
            IDLE: begin
                if (udr_rise_q && par_ok && ch_in_range) begin
                    state_d = PEND;
                    ch_d    = ir_sync;
                    jdo_d   = sr[DR_W-1:0];
                end
            end
            PEND: begin
                // A second update while pending is dropped but flagged.
                if (udr_rise_q && par_ok) begin
                    ovr_set = 1'b1;
                end
                if (act_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        ovr_d = ovr_set ? 1'b1 : (clr_ovr ? 1'b0 : ovr);
        for (int k = 0; k < int'(NUM_CH); k++) begin
            act_valid_d[k] = (state_d == PEND) && (ch_d == IR_W'(k));
        end
        status_d[IR_OUT_PEND] = (state_d == PEND);
        status_d[IR_OUT_OVR]  = ovr_d;
        ir_out_d = IR_W'(status_d);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            ch_q      <= '0;
            jdo       <= '0;
            ovr       <= 1'b0;
            act_valid <= '0;
            ir_out    <= '0;
        end else begin
            state_q   <= state_d;
            ch_q      <= ch_d;
            jdo       <= jdo_d;
            ovr       <= ovr_d;
            act_valid <= act_valid_d;
            ir_out    <= ir_out_d;
        end
    end

`ifdef DBG_SCAN_PARITY_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            par_err <= 1'b0;
        end else begin
            par_err <= udr_rise_q && !par_ok;
        end
    end
`else
    assign par_err = 1'b0;
`endif

endmodule

// File: tb/tb_debug_scan_bridge.sv
// Bench for debug_scan_bridge: pin-level latency model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_debug_scan_bridge;

    localparam int unsigned IR_W   = 2;
    localparam int unsigned DR_W   = 38;
    localparam int unsigned NUM_CH = 3;
    localparam int unsigned S      = 2;

    logic                   clk;
    logic                   reset;
    logic                   tck;
    logic                   tdi;
    logic                   vs_cdr;
    logic                   vs_sdr;
    logic                   vs_udr;
    logic                   vs_uir;
    logic [IR_W-1:0]        ir_in;
    logic [NUM_CH*DR_W-1:0] cap_data;
    logic                   act_ready;
    logic                   clr_ovr;
    logic                   tdo;
    logic [IR_W-1:0]        ir_out;
    logic [DR_W-1:0]        jdo;
    logic [NUM_CH-1:0]      act_valid;
    logic                   ovr;
    logic                   par_err;

    debug_scan_bridge #(
        .IR_W(IR_W), .DR_W(DR_W), .NUM_CH(NUM_CH), .SYNC_STAGES(S)
    ) dut (
        .clk(clk), .reset(reset), .tck(tck), .tdi(tdi),
        .vs_cdr(vs_cdr), .vs_sdr(vs_sdr), .vs_udr(vs_udr), .vs_uir(vs_uir),
        .ir_in(ir_in), .cap_data(cap_data), .act_ready(act_ready),
        .clr_ovr(clr_ovr), .tdo(tdo), .ir_out(ir_out), .jdo(jdo),
        .act_valid(act_valid), .ovr(ovr), .par_err(par_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;
    int          cyc = 32;
    bit          rnd_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 'h%0h expected 'h%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct packed {
        logic            tck;
        logic            tdi;
        logic            cdr;
        logic            sdr;
        logic            udr;
        logic [IR_W-1:0] ir;
    } snap_t;

    snap_t           hist [16];
    logic [DR_W-1:0] m_sr, m_jdo, sr_old;
    logic            m_pend, m_ovr, m_tdo, pend_old, set_ovr;
    logic [IR_W-1:0] m_ch;

    int              av_first_cyc = -1;
    logic [NUM_CH-1:0] av_first_val;
    int              av_hi_cycles = 0;
    int              udr_set_cyc = 0;

    initial begin
        for (int i = 0; i < 16; i++) hist[i] = '0;
    end

    function automatic logic [DR_W-1:0] cap_word(input logic [IR_W-1:0] ir);
        if (int'(ir) < int'(NUM_CH)) return DR_W'(cap_data >> (int'(ir) * DR_W));
        return '0;
    endfunction

    // Model: a pin event sampled first at edge j acts at edge j+S (tck) or j+S+1 (udr).
    always @(posedge clk) begin
        snap_t s, t1, t0, u1, u0, ui;
        #1;
        cyc++;
        s = reset ? snap_t'(0) : snap_t'{tck, tdi, vs_cdr, vs_sdr, vs_udr, ir_in};
        hist[cyc % 16] = s;
        if (reset) begin
            m_sr = '0; m_jdo = '0; m_pend = 1'b0; m_ovr = 1'b0; m_tdo = 1'b0; m_ch = '0;
        end else begin
            t1 = hist[(cyc - S) % 16];
            t0 = hist[(cyc - S - 1) % 16];
            u1 = hist[(cyc - S - 1) % 16];
            u0 = hist[(cyc - S - 2) % 16];
            ui = hist[(cyc - S) % 16];
            sr_old   = m_sr;
            pend_old = m_pend;
            set_ovr  = 1'b0;
            if (u1.udr && !u0.udr) begin
                if (pend_old) set_ovr = 1'b1;
                else if (int'(ui.ir) < int'(NUM_CH)) begin
                    m_pend = 1'b1; m_ch = ui.ir; m_jdo = sr_old;
                end
            end
            if (pend_old && act_ready) m_pend = 1'b0;
            if (set_ovr) m_ovr = 1'b1;
            else if (clr_ovr) m_ovr = 1'b0;
            if (t1.tck && !t0.tck) begin
                if (t1.cdr) m_sr = cap_word(t1.ir);
                else if (t1.sdr) m_sr = {t1.tdi, m_sr[DR_W-1:1]};
            end
            m_tdo = sr_old[0];
        end
        chk("tdo", 64'(tdo), 64'(m_tdo));
        chk("jdo", 64'(jdo), 64'(m_jdo));
        chk("act_valid", 64'(act_valid), m_pend ? 64'(NUM_CH'(1) << m_ch) : 64'd0);
        chk("ovr", 64'(ovr), 64'(m_ovr));
        chk("ir_out", 64'(ir_out), 64'({m_ovr, m_pend}));
        chk("par_err", 64'(par_err), 64'd0);
        if (act_valid != '0) begin
            av_hi_cycles++;
            if (av_first_cyc < 0) begin
                av_first_cyc = cyc;
                av_first_val = act_valid;
            end
        end
    end

    always @(negedge clk) begin
        if (rnd_en) begin
            act_ready = ($urandom % 3) != 0;
            clr_ovr   = ($urandom % 8) == 0;
        end
    end

    task automatic tck_pulse(input logic cdr, input logic sdr, input logic d);
        @(negedge clk); vs_cdr = cdr; vs_sdr = sdr; tdi = d;
        repeat (2) @(negedge clk); tck = 1'b1;
        repeat (4) @(negedge clk); tck = 1'b0;
        repeat (2) @(negedge clk); vs_cdr = 1'b0; vs_sdr = 1'b0;
    endtask

    task automatic shift_word(input logic [DR_W-1:0] w);
        for (int i = 0; i < int'(DR_W); i++) tck_pulse(1'b0, 1'b1, w[i]);
    endtask

    task automatic udr_pulse(input logic [IR_W-1:0] ir);
        @(negedge clk); ir_in = ir;
        repeat (2) @(negedge clk);
        vs_udr = 1'b1;
        udr_set_cyc = cyc;
        repeat (4) @(negedge clk); vs_udr = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic arm_av;
        av_first_cyc = -1;
        av_hi_cycles = 0;
    endtask

    logic [DR_W-1:0] bits, word_a, word_b, word_c;

    initial begin
        reset = 1'b1; tck = 1'b0; tdi = 1'b0; vs_cdr = 1'b0; vs_sdr = 1'b0;
        vs_udr = 1'b0; vs_uir = 1'b0; ir_in = '0; act_ready = 1'b0; clr_ovr = 1'b0;
        cap_data = '0;
        cap_data[0 +: DR_W]      = DR_W'({$urandom, $urandom});
        cap_data[DR_W +: DR_W]   = DR_W'({$urandom, $urandom});
        cap_data[2*DR_W +: DR_W] = 38'h2A_DEAD_BEEF;
        repeat (3) @(negedge clk);
        chk("reset_tdo", 64'(tdo), 64'd0);
        chk("reset_jdo", 64'(jdo), 64'd0);
        chk("reset_act_valid", 64'(act_valid), 64'd0);
        chk("reset_ir_out", 64'(ir_out), 64'd0);
        reset = 1'b0;

        // Capture channel 2 and shift it out with zeros behind it.
        ir_in = 2'd2;
        tck_pulse(1'b1, 1'b0, 1'b0);
        bits = '0;
        bits[0] = tdo;
        for (int i = 1; i <= int'(DR_W); i++) begin
            tck_pulse(1'b0, 1'b1, 1'b0);
            if (i < int'(DR_W)) bits[i] = tdo;
        end
        chk("shift_out_word", 64'(bits), 64'h2A_DEAD_BEEF);
        chk("flushed_tdo", 64'(tdo), 64'd0);
        act_ready = 1'b1;
        arm_av();
        udr_pulse(2'd2);
        repeat (3) @(negedge clk);
        chk("flushed_jdo", 64'(jdo), 64'd0);
        chk("ch2_valid", 64'(av_first_val), 64'b100);

        // Update path: latency, one-cycle handshake, word handed over.
        shift_word(38'h15_1234_5678);
        arm_av();
        udr_pulse(2'd1);
        repeat (3) @(negedge clk);
        chk("upd_jdo", 64'(jdo), 64'h15_1234_5678);
        chk("upd_valid", 64'(av_first_val), 64'b010);
        chk("upd_valid_cycles", 64'(av_hi_cycles), 64'd1);
        chk("upd_latency", 64'(av_first_cyc - udr_set_cyc), 64'(S + 2));

        // Backpressure then overrun.
        act_ready = 1'b0;
        word_a = 38'h0A_AAAA_5555;
        word_b = 38'h3F_0000_1111;
        shift_word(word_a);
        udr_pulse(2'd0);
        shift_word(word_b);
        udr_pulse(2'd1);
        chk("ovr_jdo_kept", 64'(jdo), 64'(word_a));
        chk("ovr_flag", 64'(ovr), 64'd1);
        chk("ovr_ir_out", 64'(ir_out), 64'b11);
        chk("ovr_valid_ch", 64'(act_valid), 64'b001);
        act_ready = 1'b1;
        @(negedge clk); act_ready = 1'b0;
        @(negedge clk);
        chk("drain_valid", 64'(act_valid), 64'd0);
        chk("drain_ovr_sticky", 64'(ovr), 64'd1);
        clr_ovr = 1'b1;
        @(negedge clk); clr_ovr = 1'b0;
        @(negedge clk);
        chk("clr_ovr", 64'(ovr), 64'd0);
        chk("clr_ir_out", 64'(ir_out), 64'd0);

        // Out-of-range instruction: captures zeros, update ignored.
        ir_in = 2'd3;
        tck_pulse(1'b1, 1'b0, 1'b0);
        chk("oor_cap_tdo", 64'(tdo), 64'd0);
        arm_av();
        udr_pulse(2'd3);
        repeat (3) @(negedge clk);
        chk("oor_no_valid", 64'(av_hi_cycles), 64'd0);
        chk("oor_idle", 64'(ir_out), 64'd0);
        act_ready = 1'b1;
        udr_pulse(2'd0);
        repeat (3) @(negedge clk);
        chk("oor_sr_zero", 64'(jdo), 64'd0);

        // Asynchronous reset while pending with overrun set.
        act_ready = 1'b0;
        word_c = DR_W'({$urandom, $urandom}) | DR_W'(1);
        shift_word(word_c);
        udr_pulse(2'd1);
        udr_pulse(2'd0);
        chk("pre_rst_tdo", 64'(tdo), 64'd1);
        chk("pre_rst_ovr", 64'(ovr), 64'd1);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("arst_valid", 64'(act_valid), 64'd0);
        chk("arst_jdo", 64'(jdo), 64'd0);
        chk("arst_ovr", 64'(ovr), 64'd0);
        chk("arst_tdo", 64'(tdo), 64'd0);
        @(negedge clk); reset = 1'b0;
        word_c = DR_W'({$urandom, $urandom});
        shift_word(word_c);
        act_ready = 1'b1;
        arm_av();
        udr_pulse(2'd2);
        repeat (3) @(negedge clk);
        chk("post_rst_jdo", 64'(jdo), 64'(word_c));
        chk("post_rst_latency", 64'(av_first_cyc - udr_set_cyc), 64'(S + 2));
        chk("post_rst_cycles", 64'(av_hi_cycles), 64'd1);

        // Randomized traffic checked by the per-cycle model.
        rnd_en = 1'b1;
        for (int n = 0; n < 80; n++) begin
            case ($urandom % 4)
                0: begin
                    @(negedge clk); ir_in = IR_W'($urandom);
                    tck_pulse(1'b1, 1'b0, 1'b0);
                end
                1: begin
                    for (int b = 0; b < int'($urandom_range(1, 8)); b++)
                        tck_pulse(1'b0, 1'b1, 1'($urandom));
                end
                2: udr_pulse(IR_W'($urandom));
                default: begin
                    @(negedge clk);
                    cap_data[($urandom % NUM_CH) * DR_W +: DR_W] = DR_W'({$urandom, $urandom});
                end
            endcase
        end
        rnd_en = 1'b0;
        @(negedge clk); act_ready = 1'b1; clr_ovr = 1'b0;
        repeat (6) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, vectors %0d", vectors);
        $fatal(1);
    end

endmodule
